csa_tree_pipe: RTL and testbench
================================

// Module: csa_tree_pipe
// PURPOSE
//  Pipelined N-operand carry-save adder tree with valid/ready handshake and optional beat accumulation.
//  Reduces N packed W-bit operands with levels of 3:2 CSA rows, registers each level, and resolves
//  the result with a final carry-propagate adder. It sits after the CNN multiplier array and sums
//  partial products or kernel taps into one result per beat, or one per accumulation group.
// PARAMETERS
//  N         4  number of operands, >=3
//  W         4  operand width in bits
//  SIGNED    0  1: two's-complement operands, sign-extended; 0: unsigned, zero-extended
//  ACC_BITS  0  0: accumulator off; >0: extra result bits for beat accumulation
//  derived   OW = W + $clog2(N) + ACC_BITS; L = csa_levels(N); LAT = L+1
// PORTS
//  clk        in   1     clock, rising edge
//  rst_n      in   1     synchronous reset, active-low
//  in_data    in   N*W   operand k at [k*W +: W]
//  in_valid   in   1     operand set valid
//  in_last    in   1     last beat of accumulation group (ignored when ACC_BITS==0)
//  in_ready   out  1     pipeline can accept in_data this cycle
//  out_sum    out  OW    result
//  out_valid  out  1     out_sum valid
//  out_ready  in   1     downstream accepts out_sum
// BEHAVIOUR
//  - One clock. Reset is synchronous and active-low.
//  - Reset (rst_n=0 at clk edge): all stage valids=0, out_valid=0, out_sum=0, accumulator=0.
//    Reset mid-operation discards all in-flight beats and any partial accumulation.
//  - Extension: each operand is extended to OW bits before the tree. SIGNED=1 sign-extends.
//    SIGNED=0 zero-extends.
//  - Tree schedule: csa_levels(N): n=N; while n>2, n -= floor(n/3). Each level packs
//    floor(n/3) 3:2 rows, and leftover operands pass straight through.
//    Examples: N=3 gives L=1, N=4 gives L=2, N=9 gives L=4. Every level output is registered.
//  - CPA stage: the final 2 vectors are added full-width (OW). The result is registered.
//    Latency = LAT cycles from an accepted input to out_valid when there is no stall.
//  - Single beat never overflows within W+$clog2(N) bits. Accumulation wraps modulo 2^OW.
//  - Handshake: transfer occurs when valid&&ready. in_ready = !(out_valid && !out_ready), combinational.
//    A stall freezes every pipeline stage together (global enable). Bubbles are not compressed.
//    out_sum and out_valid stay stable while out_valid=1 and out_ready=0.
//  - Throughput: 1 result per cycle when out_ready is held at 1.
//  - ACC_BITS==0: every accepted beat produces exactly one result.
//  - ACC_BITS>0: each CPA result is added into acc_q. A beat flagged in_last presents acc_q+sum
//    on out_sum with out_valid=1, and acc_q clears to 0 in the same cycle that beat leaves the CPA.
//    Non-last beats produce out_valid=0. in_last travels through the pipeline with its beat.
//    A group of length 1 (in_last on the first beat) is legal.
//  - in_data sampled while in_valid=0, or while in_ready=0, has no effect.
// STRUCTURE
//  - Shared package csa_pkg:
//      function csa_levels(int n)
//      function csa_out_w(w, n, acc)
//  - Sub-module csa_row #(WD): combinational 3:2 row of WD full_adder cells, x+y+z -> s,c.
//    c is shifted left by one at instantiation. Instantiated per triple per level by generate loops.
//  - Top level holds the stage registers, the valid/last shift chain, the CPA and the accumulator.
// TESTING
//  1 N=4 W=4: in=15,15,15,15, one beat, out_ready=1 -> out_sum=60 and out_valid high exactly 3 cycles later.
//  2 N=9 W=8: 9 back-to-back beats with in_data k*W+:W = beat+k -> results 36+9*beat,
//    one per cycle, first at cycle 5.
//  3 Backpressure: hold out_ready=0 for 4 cycles with the pipe full -> in_ready=0, out_sum stable,
//    no beat lost or duplicated after release.
//  4 SIGNED=1 N=3 W=4: operands -8,-8,7 -> out_sum=-9 (OW=6: 6'b110111).
//  5 ACC_BITS=4 N=4 W=4: 3 beats of all-ones (60 each), in_last on the 3rd -> single out_sum=180.
//    The next group starts from 0.
//  6 rst_n=0 for 1 cycle with 2 beats in flight and a partial accumulation -> no out_valid follows,
//    and the next group sums from 0.

Source files
------------

// File: rtl/csa_pkg.sv
// csa_pkg: level schedule and width helpers for the
// pipelined carry-save adder tree.
package csa_pkg;

  function automatic int csa_levels(int n);
    int l;
    l = 0;
    while (n > 2) begin
      n -= n / 3;
      l++;
    end
    return l;
  endfunction

  // operand count entering level l
  function automatic int csa_cnt(int n, int l);
    for (int i = 0; i < l; i++) n -= n / 3;
    return n;
  endfunction

  function automatic int csa_out_w(int w, int n, int acc);
    return w + $clog2(n) + acc;
  endfunction

endpackage

// File: rtl/csa_row.sv
// csa_row: one 3:2 carry-save row built from
// full_adder cells, x+y+z -> s + (c << 1).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module csa_row #(
  parameter int WD = 4
) (
  input  logic [WD-1:0] x,
  input  logic [WD-1:0] y,
  input  logic [WD-1:0] z,
  output logic [WD-1:0] s,
  output logic [WD-1:0] c
);
  for (genvar b = 0; b < WD; b++) begin : g_fa
    full_adder u_fa (
      .a (x[b]),
      .b (y[b]),
      .ci(z[b]),
      .s (s[b]),
      .co(c[b])
    );
  end
endmodule

// File: rtl/csa_tree_pipe.sv
// csa_tree_pipe: pipelined N-operand CSA tree with CPA,
// valid/ready stall and optional group accumulation.
module csa_tree_pipe
  import csa_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 4,
  parameter int SIGNED   = 0,
  parameter int ACC_BITS = 0,
  localparam int OW      = csa_out_w(W, N, ACC_BITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [OW-1:0] out_sum,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int L = csa_levels(N);

  logic          en;
  logic [OW-1:0] ext [N];
  logic [OW-1:0] nx  [L][N];
  logic [OW-1:0] stg [L][N];
  logic [L-1:0]  vld;
  logic [L-1:0]  lst;
  logic [OW-1:0] sum;
  logic [OW-1:0] acc_q;

  // whole pipe freezes while the output is held
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  for (genvar k = 0; k < N; k++) begin : g_ext
    if (SIGNED != 0) begin : g_s
      assign ext[k] = {{(OW-W){in_data[k*W+W-1]}},
                       in_data[k*W +: W]};
    end else begin : g_u
      assign ext[k] = {{(OW-W){1'b0}}, in_data[k*W +: W]};
    end
  end

  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int NI = csa_cnt(N, l);
    localparam int T  = NI / 3;
    localparam int NO = NI - T;
    logic [OW-1:0] src [N];

    for (genvar k = 0; k < N; k++) begin : g_src
      if (l == 0) begin : g_in
        assign src[k] = ext[k];
      end else begin : g_reg
        assign src[k] = stg[l-1][k];
      end
    end

    for (genvar i = 0; i < T; i++) begin : g_row
      logic [OW-1:0] s;
      logic [OW-1:0] c;
      csa_row #(.WD(OW)) u_row (
        .x(src[3*i]),
        .y(src[3*i+1]),
        .z(src[3*i+2]),
        .s(s),
        .c(c)
      );
      assign nx[l][2*i]   = s;
      assign nx[l][2*i+1] = {c[OW-2:0], 1'b0};
    end

    // leftovers pass straight through
    for (genvar j = 3*T; j < NI; j++) begin : g_pass
      assign nx[l][j-T] = src[j];
    end

    for (genvar j = NO; j < N; j++) begin : g_zero
      assign nx[l][j] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      lst <= '0;
    end else if (en) begin
      vld[0] <= in_valid;
      lst[0] <= in_last;
      for (int l = 1; l < L; l++) begin
        vld[l] <= vld[l-1];
        lst[l] <= lst[l-1];
      end
      for (int l = 0; l < L; l++) begin
        for (int k = 0; k < N; k++) begin
          stg[l][k] <= nx[l][k];
        end
      end
    end
  end

  assign sum = stg[L-1][0] + stg[L-1][1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      acc_q     <= '0;
    end else if (en) begin
      if (ACC_BITS == 0) begin
        out_valid <= vld[L-1];
        if (vld[L-1]) out_sum <= sum;
      end else begin
        out_valid <= vld[L-1] && lst[L-1];
        if (vld[L-1]) begin
          if (lst[L-1]) begin
            out_sum <= acc_q + sum;
            acc_q   <= '0;
          end else begin
            acc_q <= acc_q + sum;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_csa_tree_pipe.sv
// tb_csa_tree_pipe: directed checks over four
// csa_tree_pipe configurations.
module tb_csa_tree_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // N=4 W=4 unsigned
  logic [15:0] a_data = '0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [5:0]  a_sum;
  logic        a_oval;
  logic        a_ordy = 1'b1;

  // N=9 W=8 unsigned
  logic [71:0] b_data = '0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [11:0] b_sum;
  logic        b_oval;
  logic        b_ordy = 1'b1;

  // N=3 W=4 signed
  logic [11:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [5:0]  s_sum;
  logic        s_oval;
  logic        s_ordy = 1'b1;

  // N=4 W=4 ACC_BITS=4
  logic [15:0] c_data = '0;
  logic        c_valid = 1'b0;
  logic        c_last = 1'b0;
  logic        c_ready;
  logic [9:0]  c_sum;
  logic        c_oval;
  logic        c_ordy = 1'b1;

  csa_tree_pipe #(.N(4), .W(4), .SIGNED(0), .ACC_BITS(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid),
    .in_last(1'b0), .in_ready(a_ready), .out_sum(a_sum),
    .out_valid(a_oval), .out_ready(a_ordy)
  );

  csa_tree_pipe #(.N(9), .W(8), .SIGNED(0), .ACC_BITS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid),
    .in_last(1'b0), .in_ready(b_ready), .out_sum(b_sum),
    .out_valid(b_oval), .out_ready(b_ordy)
  );

  csa_tree_pipe #(.N(3), .W(4), .SIGNED(1), .ACC_BITS(0)) u_s (
    .clk(clk), .rst_n(rst_n), .in_data(s_data), .in_valid(s_valid),
    .in_last(1'b0), .in_ready(s_ready), .out_sum(s_sum),
    .out_valid(s_oval), .out_ready(s_ordy)
  );

  csa_tree_pipe #(.N(4), .W(4), .SIGNED(0), .ACC_BITS(4)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_valid),
    .in_last(c_last), .in_ready(c_ready), .out_sum(c_sum),
    .out_valid(c_oval), .out_ready(c_ordy)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (a_oval !== 1'b0) begin
      failures++;
      $display("FAIL reset_a_valid got=%0d exp=0", a_oval);
    end
    checks++;
    if (a_sum !== 6'd0) begin
      failures++;
      $display("FAIL reset_a_sum got=%0d exp=0", a_sum);
    end
    checks++;
    if (c_oval !== 1'b0 || c_sum !== 10'd0) begin
      failures++;
      $display("FAIL reset_c got=%0d/%0d exp=0/0", c_oval, c_sum);
    end
    checks++;
    if (a_ready !== 1'b1 || b_oval !== 1'b0 || s_oval !== 1'b0) begin
      failures++;
      $display("FAIL reset_misc got=%0d%0d%0d exp=100",
               a_ready, b_oval, s_oval);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    a_data  = 16'hFFFF;
    a_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) a_valid = 1'b0;
      checks++;
      if (a_oval !== (i == 3)) begin
        failures++;
        $display("FAIL single_valid c%0d got=%0d exp=%0d",
                 i, a_oval, (i == 3));
      end
      if (i == 3) begin
        checks++;
        if (a_sum !== 6'd60) begin
          failures++;
          $display("FAIL single_sum got=%0d exp=60", a_sum);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic ev;
    logic [11:0] es;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      ev = (c >= 5 && c < 14);
      es = 12'(36 + 9 * (c - 5));
      checks++;
      if (b_oval !== ev) begin
        failures++;
        $display("FAIL b2b_valid c%0d got=%0d exp=%0d", c, b_oval, ev);
      end
      if (ev) begin
        checks++;
        if (b_sum !== es) begin
          failures++;
          $display("FAIL b2b_sum c%0d got=%0d exp=%0d", c, b_sum, es);
        end
      end
      b_valid = (c < 9);
      for (int k = 0; k < 9; k++) b_data[k*8 +: 8] = 8'(c + k);
    end
    b_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int j;
    int got;
    logic prev_stall;
    logic [5:0] held;
    j = 0;
    got = 0;
    prev_stall = 1'b0;
    held = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      a_ordy  = !(c >= 4 && c < 8);
      a_valid = (j < 6);
      a_data  = {4{4'(j + 1)}};
      #1;
      if (a_oval && !a_ordy) begin
        checks++;
        if (a_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_in_ready c%0d got=%0d exp=0", c, a_ready);
        end
        if (prev_stall) begin
          checks++;
          if (a_sum !== held) begin
            failures++;
            $display("FAIL bp_stable c%0d got=%0d exp=%0d",
                     c, a_sum, held);
          end
        end
        held = a_sum;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (a_oval && a_ordy) begin
        checks++;
        if (a_sum !== 6'(4 * (got + 1))) begin
          failures++;
          $display("FAIL bp_seq n%0d got=%0d exp=%0d",
                   got, a_sum, 4 * (got + 1));
        end
        got++;
      end
      if (a_valid && a_ready) j++;
    end
    a_valid = 1'b0;
    a_ordy  = 1'b1;
    checks++;
    if (got !== 6) begin
      failures++;
      $display("FAIL bp_count got=%0d exp=6", got);
    end
  endtask

  task automatic test_signed();
    logic [11:0] vin [3];
    logic [5:0]  vex [3];
    logic ev;
    vin[0] = {4'h7, 4'h8, 4'h8};
    vin[1] = {4'h7, 4'h7, 4'h7};
    vin[2] = {4'hF, 4'hF, 4'hF};
    vex[0] = 6'b110111;
    vex[1] = 6'b010101;
    vex[2] = 6'b111101;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      ev = (c >= 2 && c < 5);
      checks++;
      if (s_oval !== ev) begin
        failures++;
        $display("FAIL signed_valid c%0d got=%0d exp=%0d", c, s_oval, ev);
      end
      if (ev) begin
        checks++;
        if (s_sum !== vex[c-2]) begin
          failures++;
          $display("FAIL signed_sum c%0d got=%b exp=%b",
                   c, s_sum, vex[c-2]);
        end
      end
      s_valid = (c < 3);
      if (c < 3) s_data = vin[c];
    end
    s_valid = 1'b0;
  endtask

  task automatic test_acc();
    logic ev;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      ev = (c == 5 || c == 7);
      checks++;
      if (c_oval !== ev) begin
        failures++;
        $display("FAIL acc_valid c%0d got=%0d exp=%0d", c, c_oval, ev);
      end
      if (c == 5) begin
        checks++;
        if (c_sum !== 10'd180) begin
          failures++;
          $display("FAIL acc_group1 got=%0d exp=180", c_sum);
        end
      end
      if (c == 7) begin
        checks++;
        if (c_sum !== 10'd8) begin
          failures++;
          $display("FAIL acc_group2 got=%0d exp=8", c_sum);
        end
      end
      c_valid = (c < 5);
      c_data  = (c < 3) ? 16'hFFFF : 16'h1111;
      c_last  = (c == 2 || c == 4);
    end
    c_valid = 1'b0;
    c_last  = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      c_valid = 1'b1;
      c_data  = 16'hFFFF;
      c_last  = (c == 2);
      a_valid = (c == 2);
      a_data  = 16'hFFFF;
    end
    @(negedge clk);
    c_valid = 1'b0;
    c_last  = 1'b0;
    a_valid = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (c_oval !== 1'b0 || a_oval !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_quiet c%0d got=%0d%0d exp=00",
                 i, c_oval, a_oval);
      end
      @(negedge clk);
    end
    c_valid = 1'b1;
    c_data  = 16'h1111;
    c_last  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        c_valid = 1'b0;
        c_last  = 1'b0;
      end
      checks++;
      if (c_oval !== (i == 3)) begin
        failures++;
        $display("FAIL rstmid_valid c%0d got=%0d exp=%0d",
                 i, c_oval, (i == 3));
      end
      if (i == 3) begin
        checks++;
        if (c_sum !== 10'd4) begin
          failures++;
          $display("FAIL rstmid_sum got=%0d exp=4", c_sum);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_signed();
    test_acc();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
